// File: rtl/ccu_snoop_ctrl.sv
// rtl/ccu_snoop_ctrl.sv - ACE read coherency controller: snoop broadcast, CD forward or memory fallback.
// Optional CCU_SNOOP_SHARED_EN drives RRESP IsShared/PassDirty from the snoop responses.

module ccu_snoop_ctrl #(
  parameter int NoMstPorts = 4,
  parameter int AddrWidth  = 32,
  parameter int DataWidth  = 64,
  parameter int IdWidth    = 4,
  localparam int SrcW      = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            ar_valid_i,
  output logic                            ar_ready_o,
  input  logic [AddrWidth-1:0]            ar_addr_i,
  input  logic [IdWidth-1:0]              ar_id_i,
  input  logic [7:0]                      ar_len_i,
  input  logic [3:0]                      ar_snoop_i,
  input  logic [SrcW-1:0]                 ar_src_i,
  output logic                            r_valid_o,
  input  logic                            r_ready_i,
  output logic [DataWidth-1:0]            r_data_o,
  output logic [IdWidth-1:0]              r_id_o,
  output logic                            r_last_o,
  output logic [3:0]                      r_resp_o,
  output logic                            mem_ar_valid_o,
  input  logic                            mem_ar_ready_i,
  output logic [AddrWidth-1:0]            mem_ar_addr_o,
  output logic [IdWidth-1:0]              mem_ar_id_o,
  output logic [7:0]                      mem_ar_len_o,
  input  logic                            mem_r_valid_i,
  output logic                            mem_r_ready_o,
  input  logic [DataWidth-1:0]            mem_r_data_i,
  input  logic                            mem_r_last_i,
  output logic [NoMstPorts-1:0]           ac_valid_o,
  input  logic [NoMstPorts-1:0]           ac_ready_i,
  output logic [AddrWidth-1:0]            ac_addr_o,
  output logic [3:0]                      ac_snoop_o,
  input  logic [NoMstPorts-1:0]           cr_valid_i,
  output logic [NoMstPorts-1:0]           cr_ready_o,
  input  logic [5*NoMstPorts-1:0]         cr_resp_i,
  input  logic [NoMstPorts-1:0]           cd_valid_i,
  output logic [NoMstPorts-1:0]           cd_ready_o,
  input  logic [DataWidth*NoMstPorts-1:0] cd_data_i,
  input  logic [NoMstPorts-1:0]           cd_last_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_SNOOP, S_FWD_DATA, S_MEM_REQ, S_MEM_DATA
  } state_e;

  state_e                 r_state, w_state_nxt;
  logic [AddrWidth-1:0]   r_addr;
  logic [IdWidth-1:0]     r_id;
  logic [7:0]             r_len;
  logic [3:0]             r_snoop;
  logic [NoMstPorts-1:0]  r_tgt_mask, r_ac_done, r_cr_done, r_dt_mask, r_pd_mask, r_drain_done;
  logic                   r_err, r_shared, r_src_done;
  logic [SrcW-1:0]        r_src_port;

  logic [NoMstPorts-1:0]  w_ar_tgt, w_ac_pend, w_cr_pend, w_ac_hs, w_cr_hs;
  logic [NoMstPorts-1:0]  w_cr_dt, w_cr_err, w_cr_pd, w_cr_shd, w_cr_wu;
  logic [NoMstPorts-1:0]  w_dt_all, w_cr_all, w_src_bit, w_drain_mask, w_drain_rdy, w_drain_last_hs;
  logic [SrcW-1:0]        w_first_dt;
  logic                   w_snoop_done, w_drain_complete, w_src_last_hs, w_mem_last_hs;
  logic                   w_cd_sel_valid, w_cd_sel_last;
  logic [DataWidth-1:0]   w_cd_sel_data;
  logic [1:0]             w_resp_hi;
  logic [3:0]             w_resp;
  logic                   w_unused_ok;

  always_comb begin
    w_cr_dt  = '0;
    w_cr_err = '0;
    w_cr_pd  = '0;
    w_cr_shd = '0;
    w_cr_wu  = '0;
    for (int i = 0; i < NoMstPorts; i++) begin
      w_cr_dt[i]  = cr_resp_i[5*i];
      w_cr_err[i] = cr_resp_i[5*i+1];
      w_cr_pd[i]  = cr_resp_i[5*i+2];
      w_cr_shd[i] = cr_resp_i[5*i+3];
      w_cr_wu[i]  = cr_resp_i[5*i+4];
    end
  end

  // An out-of-range initiator index means nobody is excluded from the snoop.
  always_comb begin
    w_ar_tgt = '1;
    if ({1'b0, ar_src_i} < (SrcW+1)'(NoMstPorts))
      w_ar_tgt[ar_src_i] = 1'b0;
  end

  assign w_ac_pend    = r_tgt_mask & ~r_ac_done;
  assign w_cr_pend    = r_tgt_mask & r_ac_done & ~r_cr_done;
  assign w_ac_hs      = (r_state == S_SNOOP) ? (w_ac_pend & ac_ready_i) : '0;
  assign w_cr_hs      = (r_state == S_SNOOP) ? (w_cr_pend & cr_valid_i) : '0;
  assign w_cr_all     = r_cr_done | w_cr_hs;
  assign w_dt_all     = r_dt_mask | (w_cr_hs & w_cr_dt);
  assign w_snoop_done = ((w_cr_all & r_tgt_mask) == r_tgt_mask);

  always_comb begin
    w_first_dt = '0;
    for (int i = NoMstPorts - 1; i >= 0; i--)
      if (w_dt_all[i]) w_first_dt = SrcW'(i);
  end

  always_comb begin
    w_src_bit = '0;
    w_src_bit[r_src_port] = 1'b1;
  end

  assign w_cd_sel_valid   = cd_valid_i[r_src_port];
  assign w_cd_sel_last    = cd_last_i[r_src_port];
  assign w_cd_sel_data    = cd_data_i[int'(r_src_port)*DataWidth +: DataWidth];
  assign w_drain_mask     = r_dt_mask & ~w_src_bit;
  assign w_drain_rdy      = w_drain_mask & ~r_drain_done;
  assign w_drain_last_hs  = (r_state == S_FWD_DATA) ? (w_drain_rdy & cd_valid_i & cd_last_i) : '0;
  assign w_drain_complete = (((r_drain_done | w_drain_last_hs) & w_drain_mask) == w_drain_mask);
  assign w_src_last_hs    = (r_state == S_FWD_DATA) && !r_src_done && w_cd_sel_valid
                            && r_ready_i && w_cd_sel_last;
  assign w_mem_last_hs    = (r_state == S_MEM_DATA) && mem_r_valid_i && r_ready_i && mem_r_last_i;

`ifdef CCU_SNOOP_SHARED_EN
  assign w_resp_hi = {r_shared, (r_state == S_FWD_DATA) ? r_pd_mask[r_src_port] : 1'b0};
`else
  assign w_resp_hi = 2'b00;
`endif
  assign w_resp      = {w_resp_hi, r_err ? 2'b10 : 2'b00};
  assign w_unused_ok = ^{w_cr_wu, w_cr_pd, w_cr_shd, r_shared, r_pd_mask};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (ar_valid_i) w_state_nxt = (|w_ar_tgt) ? S_SNOOP : S_MEM_REQ;
      S_SNOOP:    if (w_snoop_done) w_state_nxt = (|w_dt_all) ? S_FWD_DATA : S_MEM_REQ;
      S_FWD_DATA: if ((r_src_done || w_src_last_hs) && w_drain_complete) w_state_nxt = S_IDLE;
      S_MEM_REQ:  if (mem_ar_ready_i) w_state_nxt = S_MEM_DATA;
      S_MEM_DATA: if (w_mem_last_hs) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so an abort is visible in the same cycle.
  always_comb begin
    ar_ready_o     = 1'b0;
    r_valid_o      = 1'b0;
    r_data_o       = '0;
    r_id_o         = '0;
    r_last_o       = 1'b0;
    r_resp_o       = '0;
    mem_ar_valid_o = 1'b0;
    mem_ar_addr_o  = '0;
    mem_ar_id_o    = '0;
    mem_ar_len_o   = '0;
    mem_r_ready_o  = 1'b0;
    ac_valid_o     = '0;
    ac_addr_o      = '0;
    ac_snoop_o     = '0;
    cr_ready_o     = '0;
    cd_ready_o     = '0;
    if (!rst_i) begin
      case (r_state)
        S_IDLE: ar_ready_o = 1'b1;
        S_SNOOP: begin
          ac_valid_o = w_ac_pend;
          ac_addr_o  = r_addr;
          ac_snoop_o = r_snoop;
          cr_ready_o = w_cr_pend;
        end
        S_FWD_DATA: begin
          r_valid_o  = !r_src_done && w_cd_sel_valid;
          r_data_o   = w_cd_sel_data;
          r_last_o   = w_cd_sel_last;
          r_id_o     = r_id;
          r_resp_o   = w_resp;
          cd_ready_o = w_drain_rdy;
          if (!r_src_done) cd_ready_o[r_src_port] = r_ready_i;
        end
        S_MEM_REQ: begin
          mem_ar_valid_o = 1'b1;
          mem_ar_addr_o  = r_addr;
          mem_ar_id_o    = r_id;
          mem_ar_len_o   = r_len;
        end
        S_MEM_DATA: begin
          r_valid_o     = mem_r_valid_i;
          mem_r_ready_o = r_ready_i;
          r_data_o      = mem_r_data_i;
          r_last_o      = mem_r_last_i;
          r_id_o        = r_id;
          r_resp_o      = w_resp;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_id         <= '0;
      r_len        <= '0;
      r_snoop      <= '0;
      r_tgt_mask   <= '0;
      r_ac_done    <= '0;
      r_cr_done    <= '0;
      r_dt_mask    <= '0;
      r_pd_mask    <= '0;
      r_drain_done <= '0;
      r_err        <= 1'b0;
      r_shared     <= 1'b0;
      r_src_done   <= 1'b0;
      r_src_port   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (ar_valid_i) begin
          r_addr     <= ar_addr_i;
          r_id       <= ar_id_i;
          r_len      <= ar_len_i;
          r_snoop    <= ar_snoop_i;
          r_tgt_mask <= w_ar_tgt;
          r_ac_done  <= '0;
          r_cr_done  <= '0;
          r_dt_mask  <= '0;
          r_pd_mask  <= '0;
          r_err      <= 1'b0;
          r_shared   <= 1'b0;
        end
        S_SNOOP: begin
          r_ac_done <= r_ac_done | w_ac_hs;
          r_cr_done <= w_cr_all;
          r_dt_mask <= w_dt_all;
          r_pd_mask <= r_pd_mask | (w_cr_hs & w_cr_pd);
          r_err     <= r_err | (|(w_cr_hs & w_cr_err));
          r_shared  <= r_shared | (|(w_cr_hs & w_cr_shd));
          if (w_snoop_done) begin
            r_src_port   <= w_first_dt;
            r_src_done   <= 1'b0;
            r_drain_done <= '0;
          end
        end
        S_FWD_DATA: begin
          r_drain_done <= r_drain_done | w_drain_last_hs;
          if (w_src_last_hs) r_src_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ccu_snoop_ctrl.md
Name: ccu_snoop_ctrl

Overview:
- Parametrised read-path coherency controller for the CCU.
- Accepts one ACE read at a time and broadcasts a snoop to every master port except the initiator.
- Tracks AC and CR handshakes per port independently, then either forwards snoop data from the CD channel or falls back to a memory read.
- Sits between the CCU request demux and the downstream memory port; supersedes the fixed single-cycle snoop FSM.

Parameters:
- NoMstPorts, 4, number of snooped ACE masters (≥1).
- AddrWidth, 32, address width.
- DataWidth, 64, R/CD data width.
- IdWidth, 4, AXI ID width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- ar_valid_i / ar_ready_o  in/out  1  initiator AR handshake.
- ar_addr_i  in  AddrWidth  read address.
- ar_id_i  in  IdWidth  read ID.
- ar_len_i  in  8  burst length-1.
- ar_snoop_i  in  4  ARSNOOP.
- ar_src_i  in  $clog2(NoMstPorts) (min 1)  initiating port index.
- r_valid_o / r_ready_i  out/in  1  initiator R handshake.
- r_data_o  out  DataWidth  read data.
- r_id_o  out  IdWidth  read ID.
- r_last_o  out  1  last beat.
- r_resp_o  out  4  RRESP {IsShared, PassDirty, resp[1:0]}.
- mem_ar_valid_o / mem_ar_ready_i  out/in  1  memory AR handshake.
- mem_ar_addr_o, mem_ar_id_o, mem_ar_len_o  out  AddrWidth/IdWidth/8  memory AR payload.
- mem_r_valid_i / mem_r_ready_o  in/out  1  memory R handshake.
- mem_r_data_i  in  DataWidth  memory data.
- mem_r_last_i  in  1  memory last beat.
- ac_valid_o / ac_ready_i  out/in  NoMstPorts  per-port snoop address handshake.
- ac_addr_o  out  AddrWidth  shared snoop address.
- ac_snoop_o  out  4  shared snoop type.
- cr_valid_i / cr_ready_o  in/out  NoMstPorts  per-port snoop response handshake.
- cr_resp_i  in  5*NoMstPorts  CRRESP per port: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique.
- cd_valid_i / cd_ready_o  in/out  NoMstPorts  per-port snoop data handshake.
- cd_data_i  in  DataWidth*NoMstPorts  snoop data.
- cd_last_i  in  NoMstPorts  snoop data last.

Behaviour:
- Reset: state IDLE. All valid/ready outputs 0, payload outputs 0, internal masks 0. Reset mid-transaction drops the transaction without completion.
- IDLE:
  - ar_ready_o=1.
  - On AR handshake: latch addr, id, len, snoop, src.
  - tgt_mask = all ports except src; if src ≥ NoMstPorts, all ports.
  - Next state SNOOP if tgt_mask≠0, else MEM_REQ.
- SNOOP:
  - ac_valid_o[i]=1 for i in tgt_mask with AC not yet accepted. Each port drops individually after its own ac_ready_i. ac_addr_o/ac_snoop_o hold latched values.
  - cr_ready_o[i]=1 only from the cycle after port i's AC handshake until its CR handshake. A CR in the same cycle as AC is not accepted.
  - On each CR handshake: record DataTransfer, Error, PassDirty, IsShared.
  - Leave SNOOP when every tgt port has completed CR:
    - any DataTransfer → FWD_DATA; source = lowest-index port with DataTransfer.
    - otherwise → MEM_REQ.
- FWD_DATA:
  - r_valid_o = cd_valid_i[src]; cd_ready_o[src] = r_ready_i.
  - r_data_o and r_last_o are taken from the source port.
  - Every other port with DataTransfer gets cd_ready_o=1 and its data is discarded.
  - Exit to IDLE once the source last beat has handshaken and all drained ports have delivered cd_last_i.
- MEM_REQ:
  - mem_ar_valid_o=1 with latched addr/id/len, held until mem_ar_ready_i, then MEM_DATA.
- MEM_DATA:
  - Pass-through: r_valid_o = mem_r_valid_i, mem_r_ready_o = r_ready_i, r_data_o/r_last_o from memory.
  - Exit to IDLE on last-beat handshake.
- r_id_o = latched ID in FWD_DATA/MEM_DATA.
- r_resp_o[1:0] = 2'b10 (SLVERR) on every beat if any CR Error bit was set, else 2'b00.
- Combinational paths: R pass-through only; no added latency beyond one cycle per state transition.

Optional Feature:
- Macro: CCU_SNOOP_SHARED_EN.
- Defined:
  - r_resp_o[3] = OR of IsShared over all CR responses.
  - r_resp_o[2] = PassDirty of the data source port; 0 on the memory path.
- Undefined: r_resp_o[3:2] = 0 always.

Test Plan:
- NoMstPorts=4, src=0, ports 1-3 CR=5'b00000 → one mem AR (addr 0x1000, len 3); 4 R beats forwarded with r_last on beat 4; r_resp=0.
- src=2, port 3 CR DataTransfer=1, data 0xA..0xD, len 3 → no mem AR; R carries 0xA-0xD; ports 0/1 receive no cd_ready.
- Ports 1 and 3 both DataTransfer → port 1 forwarded; port 3 CD drained in parallel; return to IDLE only after both lasts.
- Staggered ac_ready (port 1 at +1, port 3 at +5 cycles) and cr_valid asserted in the AC cycle → CR accepted no earlier than the cycle after AC; ac_valid per port drops individually.
- Port 2 CR Error=1 → all R beats r_resp[1:0]=2'b10. With CCU_SNOOP_SHARED_EN and IsShared=1 → r_resp[3]=1.
- rst_i asserted in FWD_DATA mid-burst → all outputs 0 the same cycle; next AR accepted normally in IDLE.
